// File: rtl/multi_bank_req_ctrl_if.sv
// Request/response and memory-command bundle for multi_bank_req_ctrl.
// slave is the controller's view; master is the requester/memory side.
interface multi_bank_req_ctrl_if #(
   parameter int ADDR_TOTAL = 10,
   parameter int WIDTH      = 8
);
   logic                  i_valid_a;
   logic                  i_valid_b;
   logic                  o_ready_a;
   logic                  o_ready_b;
   logic                  i_we_a;
   logic                  i_we_b;
   logic [ADDR_TOTAL-1:0] i_addr_a;
   logic [ADDR_TOTAL-1:0] i_addr_b;
   logic [WIDTH-1:0]      i_din_a;
   logic [WIDTH-1:0]      i_din_b;
   logic                  o_rvalid_a;
   logic                  o_rvalid_b;
   logic [WIDTH-1:0]      o_rdata_a;
   logic [WIDTH-1:0]      o_rdata_b;
   logic                  o_mem_en_a;
   logic                  o_mem_en_b;
   logic                  o_mem_we_a;
   logic                  o_mem_we_b;
   logic [WIDTH-1:0]      o_mem_din_a;
   logic [WIDTH-1:0]      o_mem_din_b;
   logic [ADDR_TOTAL-3:0] o_mem_addr_a;
   logic [ADDR_TOTAL-3:0] o_mem_addr_b;
   logic [1:0]            o_mem_bank_sel_a;
   logic [1:0]            o_mem_bank_sel_b;
   logic [WIDTH-1:0]      i_mem_dout_a;
   logic [WIDTH-1:0]      i_mem_dout_b;

   modport slave (
      input  i_valid_a, i_valid_b, i_we_a, i_we_b, i_addr_a, i_addr_b,
      input  i_din_a, i_din_b, i_mem_dout_a, i_mem_dout_b,
      output o_ready_a, o_ready_b, o_rvalid_a, o_rvalid_b, o_rdata_a, o_rdata_b,
      output o_mem_en_a, o_mem_en_b, o_mem_we_a, o_mem_we_b,
      output o_mem_din_a, o_mem_din_b, o_mem_addr_a, o_mem_addr_b,
      output o_mem_bank_sel_a, o_mem_bank_sel_b
   );

   modport master (
      output i_valid_a, i_valid_b, i_we_a, i_we_b, i_addr_a, i_addr_b,
      output i_din_a, i_din_b, i_mem_dout_a, i_mem_dout_b,
      input  o_ready_a, o_ready_b, o_rvalid_a, o_rvalid_b, o_rdata_a, o_rdata_b,
      input  o_mem_en_a, o_mem_en_b, o_mem_we_a, o_mem_we_b,
      input  o_mem_din_a, o_mem_din_b, o_mem_addr_a, o_mem_addr_b,
      input  o_mem_bank_sel_a, o_mem_bank_sel_b
   );
endinterface

// File: rtl/multi_bank_req_ctrl.sv
// Dual-port request front-end for a 4-bank memory: same-address hazard arbitration,
// registered memory commands and tagged fixed-latency read return. Optional MBRC_STATS_EN adds counters.
module multi_bank_req_ctrl #(
   parameter int ADDR_TOTAL = 10,
   parameter int WIDTH      = 8,
   parameter int NUM_BANK   = 4,
   parameter int RD_LAT     = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   multi_bank_req_ctrl_if.slave bus
`ifdef MBRC_STATS_EN
   ,
   output logic [15:0]          o_hz_cnt,
   output logic [15:0]          o_rd_cnt
`endif
);
   localparam int BANK_BITS = $clog2(NUM_BANK);
   localparam int BANK_AW   = ADDR_TOTAL - BANK_BITS;

   logic [1:0]            valid;
   logic [1:0]            we;
   logic [1:0]            ready;
   logic [1:0]            accept;
   logic [1:0]            rd_accept;
   logic [1:0]            rvalid;
   logic [1:0]            mem_en;
   logic [1:0]            mem_we;
   logic [ADDR_TOTAL-1:0] addr     [2];
   logic [WIDTH-1:0]      din      [2];
   logic [WIDTH-1:0]      mem_dout [2];
   logic [WIDTH-1:0]      mem_din  [2];
   logic [WIDTH-1:0]      rdata    [2];
   logic [BANK_AW-1:0]    mem_addr [2];
   logic [BANK_BITS-1:0]  mem_bank [2];
   logic                  hazard;
   logic                  rr_reg;
   logic                  rr_next;

   // Index 0 is port A, index 1 is port B throughout.
   assign valid       = {bus.i_valid_b, bus.i_valid_a};
   assign we          = {bus.i_we_b, bus.i_we_a};
   assign addr[0]     = bus.i_addr_a;
   assign addr[1]     = bus.i_addr_b;
   assign din[0]      = bus.i_din_a;
   assign din[1]      = bus.i_din_b;
   assign mem_dout[0] = bus.i_mem_dout_a;
   assign mem_dout[1] = bus.i_mem_dout_b;

   // Read/read to one address is harmless; anything involving a write is serialized.
   assign hazard = valid[0] && valid[1] && (addr[0] == addr[1]) && (we[0] || we[1]);

   always_comb begin
      rr_next = rr_reg;
      ready   = 2'b00;
      if (!i_rst) begin
         if (hazard) begin
            ready   = rr_reg ? 2'b10 : 2'b01;
            rr_next = ~rr_reg;
         end else begin
            ready = 2'b11;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rr_reg <= 1'b0;
      end else begin
         rr_reg <= rr_next;
      end
   end

   assign accept    = valid & ready;
   assign rd_accept = accept & ~we;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic                 en_reg;
         logic                 we_reg;
         logic [BANK_AW-1:0]   addr_reg;
         logic [BANK_BITS-1:0] bank_reg;
         logic [WIDTH-1:0]     din_reg;
         logic [RD_LAT:0]      tag_reg;

         // Address/data registers hold across idle cycles; only enables drop.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               en_reg   <= 1'b0;
               we_reg   <= 1'b0;
               addr_reg <= '0;
               bank_reg <= '0;
               din_reg  <= '0;
               tag_reg  <= '0;
            end else begin
               en_reg  <= accept[gi];
               we_reg  <= accept[gi] && we[gi];
               tag_reg <= {tag_reg[RD_LAT-1:0], rd_accept[gi]};
               if (accept[gi]) begin
                  addr_reg <= addr[gi][BANK_AW-1:0];
                  bank_reg <= addr[gi][ADDR_TOTAL-1:BANK_AW];
                  din_reg  <= din[gi];
               end
            end
         end

         // The tag reaches the last stage in the same cycle the memory presents the read word.
         assign mem_en[gi]   = en_reg;
         assign mem_we[gi]   = we_reg;
         assign mem_addr[gi] = addr_reg;
         assign mem_bank[gi] = bank_reg;
         assign mem_din[gi]  = din_reg;
         assign rvalid[gi]   = tag_reg[RD_LAT];
         assign rdata[gi]    = tag_reg[RD_LAT] ? mem_dout[gi] : '0;
      end
   endgenerate

   assign bus.o_ready_a        = ready[0];
   assign bus.o_ready_b        = ready[1];
   assign bus.o_mem_en_a       = mem_en[0];
   assign bus.o_mem_en_b       = mem_en[1];
   assign bus.o_mem_we_a       = mem_we[0];
   assign bus.o_mem_we_b       = mem_we[1];
   assign bus.o_mem_addr_a     = mem_addr[0];
   assign bus.o_mem_addr_b     = mem_addr[1];
   assign bus.o_mem_bank_sel_a = mem_bank[0];
   assign bus.o_mem_bank_sel_b = mem_bank[1];
   assign bus.o_mem_din_a      = mem_din[0];
   assign bus.o_mem_din_b      = mem_din[1];
   assign bus.o_rvalid_a       = rvalid[0];
   assign bus.o_rvalid_b       = rvalid[1];
   assign bus.o_rdata_a        = rdata[0];
   assign bus.o_rdata_b        = rdata[1];

`ifdef MBRC_STATS_EN
   logic [15:0] hz_cnt_reg;
   logic [15:0] rd_cnt_reg;
   logic [16:0] rd_sum;

   assign rd_sum = {1'b0, rd_cnt_reg} + {16'd0, rd_accept[0]} + {16'd0, rd_accept[1]};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hz_cnt_reg <= '0;
         rd_cnt_reg <= '0;
      end else begin
         if (hazard && (hz_cnt_reg != 16'hFFFF)) begin
            hz_cnt_reg <= hz_cnt_reg + 16'd1;
         end
         rd_cnt_reg <= rd_sum[16] ? 16'hFFFF : rd_sum[15:0];
      end
   end

   assign o_hz_cnt = hz_cnt_reg;
   assign o_rd_cnt = rd_cnt_reg;
`endif
endmodule

// File: tb/tb_multi_bank_req_ctrl.sv
// Directed + random bench for multi_bank_req_ctrl against a transaction-level model
// (shadow memory, arbitration rules, queue of due read returns) and a simple memory model.
module tb_multi_bank_req_ctrl;
   localparam int AT     = 10;
   localparam int W      = 8;
   localparam int RD_LAT = 1;

   typedef struct {
      int           port;
      int           due;
      logic [W-1:0] data;
   } ret_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multi_bank_req_ctrl_if #(.ADDR_TOTAL(AT), .WIDTH(W)) bus ();

`ifdef MBRC_STATS_EN
   logic [15:0] hz_cnt;
   logic [15:0] rd_cnt;
`endif

   multi_bank_req_ctrl #(.ADDR_TOTAL(AT), .WIDTH(W), .NUM_BANK(4), .RD_LAT(RD_LAT)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
`ifdef MBRC_STATS_EN
      ,
      .o_hz_cnt (hz_cnt),
      .o_rd_cnt (rd_cnt)
`endif
   );

   function automatic logic [W-1:0] init_val(input int i);
      return W'((i * 37) ^ (i >> 3) ^ 8'hA5);
   endfunction

   // Memory behind the controller: writes at the edge, reads visible RD_LAT cycles after the command.
   logic [W-1:0] mem_arr [1<<AT];
   logic [W-1:0] pipe_a [RD_LAT];
   logic [W-1:0] pipe_b [RD_LAT];
   logic         mem_init_done = 1'b0;

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < (1 << AT); i++) mem_arr[i] <= init_val(i);
         mem_init_done <= 1'b1;
      end else begin
         if (bus.o_mem_en_a && !bus.o_mem_we_a) pipe_a[0] <= mem_arr[{bus.o_mem_bank_sel_a, bus.o_mem_addr_a}];
         if (bus.o_mem_en_b && !bus.o_mem_we_b) pipe_b[0] <= mem_arr[{bus.o_mem_bank_sel_b, bus.o_mem_addr_b}];
         for (int k = 1; k < RD_LAT; k++) begin
            pipe_a[k] <= pipe_a[k-1];
            pipe_b[k] <= pipe_b[k-1];
         end
         if (bus.o_mem_en_a && bus.o_mem_we_a) mem_arr[{bus.o_mem_bank_sel_a, bus.o_mem_addr_a}] <= bus.o_mem_din_a;
         if (bus.o_mem_en_b && bus.o_mem_we_b) mem_arr[{bus.o_mem_bank_sel_b, bus.o_mem_addr_b}] <= bus.o_mem_din_b;
      end
   end

   assign bus.i_mem_dout_a = pipe_a[RD_LAT-1];
   assign bus.i_mem_dout_b = pipe_b[RD_LAT-1];

   // Reference model state
   logic [W-1:0]  shadow [1<<AT];
   logic          rr_m;
   logic          exp_en   [2];
   logic          exp_we   [2];
   logic [AT-1:0] exp_addr [2];
   logic [W-1:0]  exp_din  [2];
   logic [1:0]    last_acc;
   ret_t          ret_q [$];
   int            hz_m;
   int            rd_m;
   int            cyc;
   int            n_vec = 0;
   int            n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         exp_en[p]   = 1'b0;
         exp_we[p]   = 1'b0;
         exp_addr[p] = '0;
         exp_din[p]  = '0;
      end
      ret_q.delete();
      rr_m     = 1'b0;
      hz_m     = 0;
      rd_m     = 0;
      last_acc = 2'b00;
   endtask

   // One clock: drive, check mid-cycle against the model, then advance the model.
   task automatic cycle(input logic r,
                        input logic va, input logic wa, input logic [AT-1:0] aa, input logic [W-1:0] da,
                        input logic vb, input logic wb, input logic [AT-1:0] ab, input logic [W-1:0] db);
      logic [1:0]    v, w, rdy, acc;
      logic          hz;
      logic [AT-1:0] a [2];
      logic [W-1:0]  d [2];
      logic          o_rdy [2], o_en [2], o_we [2], o_rv [2];
      logic [AT-3:0] o_addr [2];
      logic [1:0]    o_bank [2];
      logic [W-1:0]  o_din [2], o_rd [2];
      string         pn;
      int            found;

      rst = r;
      bus.i_valid_a = va; bus.i_we_a = wa; bus.i_addr_a = aa; bus.i_din_a = da;
      bus.i_valid_b = vb; bus.i_we_b = wb; bus.i_addr_b = ab; bus.i_din_b = db;
      v = {vb, va}; w = {wb, wa};
      a[0] = aa; a[1] = ab; d[0] = da; d[1] = db;

      @(negedge clk);
      hz  = v[0] && v[1] && (a[0] == a[1]) && (w[0] || w[1]);
      rdy = r ? 2'b00 : (!hz ? 2'b11 : (rr_m ? 2'b10 : 2'b01));
      acc = v & rdy;

      o_rdy[0] = bus.o_ready_a;  o_rdy[1] = bus.o_ready_b;
      o_en[0]  = bus.o_mem_en_a; o_en[1]  = bus.o_mem_en_b;
      o_we[0]  = bus.o_mem_we_a; o_we[1]  = bus.o_mem_we_b;
      o_addr[0] = bus.o_mem_addr_a;     o_addr[1] = bus.o_mem_addr_b;
      o_bank[0] = bus.o_mem_bank_sel_a; o_bank[1] = bus.o_mem_bank_sel_b;
      o_din[0] = bus.o_mem_din_a; o_din[1] = bus.o_mem_din_b;
      o_rv[0]  = bus.o_rvalid_a;  o_rv[1]  = bus.o_rvalid_b;
      o_rd[0]  = bus.o_rdata_a;   o_rd[1]  = bus.o_rdata_b;

      for (int p = 0; p < 2; p++) begin
         pn = (p == 0) ? "a" : "b";
         chk({"ready_", pn},    32'(o_rdy[p]),  32'(rdy[p]));
         chk({"mem_en_", pn},   32'(o_en[p]),   32'(exp_en[p]));
         chk({"mem_we_", pn},   32'(o_we[p]),   32'(exp_we[p]));
         chk({"mem_addr_", pn}, 32'(o_addr[p]), 32'(exp_addr[p][AT-3:0]));
         chk({"mem_bank_", pn}, 32'(o_bank[p]), 32'(exp_addr[p][AT-1:AT-2]));
         chk({"mem_din_", pn},  32'(o_din[p]),  32'(exp_din[p]));
         found = -1;
         foreach (ret_q[i]) if (ret_q[i].port == p && ret_q[i].due == cyc) found = i;
         chk({"rvalid_", pn}, 32'(o_rv[p]), 32'(found >= 0));
         if (found >= 0) begin
            chk({"rdata_", pn}, 32'(o_rd[p]), 32'(ret_q[found].data));
            ret_q.delete(found);
         end
      end
`ifdef MBRC_STATS_EN
      chk("hz_cnt", 32'(hz_cnt), 32'(hz_m));
      chk("rd_cnt", 32'(rd_cnt), 32'(rd_m));
`endif

      if (r) begin
         model_reset();
      end else begin
         if (hz) begin
            rr_m = ~rr_m;
            if (hz_m < 65535) hz_m++;
         end
         for (int p = 0; p < 2; p++) begin
            exp_en[p] = acc[p];
            exp_we[p] = acc[p] && w[p];
            if (acc[p]) begin
               exp_addr[p] = a[p];
               exp_din[p]  = d[p];
               if (!w[p]) begin
                  ret_q.push_back('{port: p, due: cyc + 1 + RD_LAT, data: shadow[a[p]]});
                  if (rd_m < 65535) rd_m++;
               end
            end
         end
         for (int p = 0; p < 2; p++) if (acc[p] && w[p]) shadow[a[p]] = d[p];
         last_acc = acc;
      end

      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      logic          rv [2];
      logic          rw [2];
      logic [AT-1:0] ra [2];
      logic [W-1:0]  rdd [2];
      logic          r;

      for (int i = 0; i < (1 << AT); i++) shadow[i] = init_val(i);
      rst = 1'b1;
      bus.i_valid_a = 1'b0; bus.i_we_a = 1'b0; bus.i_addr_a = '0; bus.i_din_a = '0;
      bus.i_valid_b = 1'b0; bus.i_we_b = 1'b0; bus.i_addr_b = '0; bus.i_din_b = '0;
      cyc = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // Reset held with requests offered: nothing ready, nothing issued
      cycle(1'b1, 1'b1, 1'b0, 10'h001, 8'h00, 1'b1, 1'b1, 10'h002, 8'h11);
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      idle(10);

      // A writes 0x123 while B reads 0x045
      cycle(1'b0, 1'b1, 1'b1, 10'h123, 8'h5A, 1'b1, 1'b0, 10'h045, 8'h00);
      idle(RD_LAT + 2);

      // Write/read hazard with rr=A: A first, B held and granted next cycle
      cycle(1'b0, 1'b1, 1'b1, 10'h200, 8'h3C, 1'b1, 1'b0, 10'h200, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h200, 8'h00);
      idle(RD_LAT + 2);

      // Same hazard with rr=B: B reads old data, A's write follows
      cycle(1'b0, 1'b1, 1'b1, 10'h200, 8'h55, 1'b1, 1'b0, 10'h200, 8'h00);
      cycle(1'b0, 1'b1, 1'b1, 10'h200, 8'h55, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h200, 8'h00);
      idle(RD_LAT + 2);

      // Back-to-back reads on A
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, AT'(i), 8'h00, 1'b0, 1'b0, '0, '0);
      idle(RD_LAT + 2);

      // Random traffic over a small address pool so hazards occur; losers usually persist
      rv[0] = 1'b0; rv[1] = 1'b0;
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!(rv[p] && !last_acc[p] && ($urandom_range(3) != 0))) begin
               rv[p]  = ($urandom_range(3) != 0);
               rw[p]  = 1'($urandom_range(1));
               ra[p]  = AT'($urandom_range(7)) * AT'(129);
               rdd[p] = W'($urandom);
            end
         end
         r = ($urandom_range(99) == 0);
         cycle(r, rv[0], rw[0], ra[0], rdd[0], rv[1], rw[1], ra[1], rdd[1]);
      end
      idle(RD_LAT + 2);

      // Reset with two reads in flight: their returns must never appear
      cycle(1'b0, 1'b1, 1'b0, 10'h010, 8'h00, 1'b1, 1'b0, 10'h011, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      idle(RD_LAT + 4);
      // rr must be back at A: A wins the first hazard
      cycle(1'b0, 1'b1, 1'b0, 10'h0F0, 8'h00, 1'b1, 1'b1, 10'h0F0, 8'h77);
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h0F0, 8'h77);
      idle(RD_LAT + 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
